// File: rtl/ring_meas_pkg.sv
// Shared types and defaults for the ring-oscillator frequency meter.
package ring_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } meas_state_t;

  localparam int unsigned GATE_CYCLES_DEFAULT = 25_000_000;

  function automatic int unsigned gate_cnt_width(input int unsigned gate_cycles);
    return $clog2(gate_cycles + 1);
  endfunction

endpackage

// File: rtl/ring_tick_sync.sv
// Brings an asynchronous ring-derived tick into clk_25mhz and emits a one-cycle rise pulse.
// Latency SYNC_STAGES+1 cycles; free-running, no backpressure.
module ring_tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_25mhz,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("ring_tick_sync: SYNC_STAGES must be at least 2");
  end

  // Rise detection stays masked until the chain and history flop hold only
  // post-reset samples, so a tick that is already high never looks like an edge.
  localparam int SETTLE = SYNC_STAGES + 1;
  localparam int SW     = $clog2(SETTLE + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [SW-1:0]          settle_q;
  logic                   settled;

  assign settled = (settle_q == SW'(SETTLE));

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      hist_q   <= 1'b0;
      settle_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      if (!settled) begin
        settle_q <= settle_q + SW'(1);
      end
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q & settled;

endmodule

// File: rtl/ring_freq_meter.sv
// Counts ring tick rising edges over a GATE_CYCLES window and publishes the result every GATE_CYCLES+1 cycles.
// Optional min/max tracking outputs under macro RING_FREQ_MINMAX_EN.
module ring_freq_meter
  import ring_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int          CNT_W       = 32,
  parameter int          LED_LSB     = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk_25mhz,
  input  logic             rst_n,
  input  logic             async_tick,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             meas_ovf,
  output logic [7:0]       led
`ifdef RING_FREQ_MINMAX_EN
  ,
  output logic [CNT_W-1:0] meas_min,
  output logic [CNT_W-1:0] meas_max
`endif
);

  if (CNT_W < LED_LSB + 8) begin : g_bad_led
    $error("ring_freq_meter: CNT_W must be at least LED_LSB+8");
  end
  if (GATE_CYCLES < 1) begin : g_bad_gate
    $error("ring_freq_meter: GATE_CYCLES must be at least 1");
  end

  localparam int GW = int'(gate_cnt_width(GATE_CYCLES));

  meas_state_t      state_q, state_d;
  logic [GW-1:0]    gate_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             ovf_q;
  logic             rise;
  logic             gate_done;

  ring_tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .clk_25mhz(clk_25mhz),
    .rst_n    (rst_n),
    .async_in (async_tick),
    .rise     (rise)
  );

  assign gate_done = (gate_cnt_q == GW'(GATE_CYCLES - 1));

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = GATE;
      GATE:    if (gate_done) state_d = LATCH;
      LATCH:   state_d = GATE;
      default: state_d = IDLE;
    endcase
  end

  // An edge seen during LATCH opens the next window, so no edge is dropped at the boundary.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        GATE: begin
          gate_cnt_q <= gate_cnt_q + GW'(1);
          if (rise) begin
            if (edge_cnt_q == {CNT_W{1'b1}}) begin
              ovf_q <= 1'b1;
            end else begin
              edge_cnt_q <= edge_cnt_q + CNT_W'(1);
            end
          end
        end
        LATCH: begin
          gate_cnt_q <= '0;
          edge_cnt_q <= {{(CNT_W-1){1'b0}}, rise};
          ovf_q      <= 1'b0;
        end
        default: begin
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          ovf_q      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      meas_count <= '0;
      meas_ovf   <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= (state_q == LATCH);
      if (state_q == LATCH) begin
        meas_count <= edge_cnt_q;
        meas_ovf   <= ovf_q;
      end
    end
  end

  assign led = meas_count[LED_LSB +: 8];

`ifdef RING_FREQ_MINMAX_EN
  logic have_min_q;
  logic have_max_q;

  // A saturated window pins max at all-ones and is ignored for min.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      meas_min   <= '0;
      meas_max   <= '0;
      have_min_q <= 1'b0;
      have_max_q <= 1'b0;
    end else if (state_q == LATCH) begin
      have_max_q <= 1'b1;
      if (ovf_q) begin
        meas_max <= {CNT_W{1'b1}};
      end else if (!have_max_q || (edge_cnt_q > meas_max)) begin
        meas_max <= edge_cnt_q;
      end
      if (!ovf_q && (!have_min_q || (edge_cnt_q < meas_min))) begin
        meas_min   <= edge_cnt_q;
        have_min_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ring_freq_meter.sv
module tb_ring_freq_meter;

  localparam int GA = 100;
  localparam int GB = 800;
  localparam int WB = 8;

  logic clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  logic        rst_n;
  logic        tick_a, tick_b;
  logic [31:0] cnt_a;
  logic        vld_a, ovf_a;
  logic [7:0]  led_a;
  logic [WB-1:0] cnt_b;
  logic        vld_b, ovf_b;
  logic [7:0]  led_b;
`ifdef RING_FREQ_MINMAX_EN
  logic [31:0]   min_a, max_a;
  logic [WB-1:0] min_b, max_b;
`endif

  ring_freq_meter #(.GATE_CYCLES(GA), .CNT_W(32), .LED_LSB(2), .SYNC_STAGES(2)) u_dut_a (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .async_tick(tick_a),
    .meas_count(cnt_a),
    .meas_valid(vld_a),
    .meas_ovf  (ovf_a),
    .led       (led_a)
`ifdef RING_FREQ_MINMAX_EN
    ,
    .meas_min  (min_a),
    .meas_max  (max_a)
`endif
  );

  ring_freq_meter #(.GATE_CYCLES(GB), .CNT_W(WB), .LED_LSB(0), .SYNC_STAGES(2)) u_dut_b (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .async_tick(tick_b),
    .meas_count(cnt_b),
    .meas_valid(vld_b),
    .meas_ovf  (ovf_b),
    .led       (led_b)
`ifdef RING_FREQ_MINMAX_EN
    ,
    .meas_min  (min_b),
    .meas_max  (max_b)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc, wa, wb;
  int a_run;
  bit a_lvl;
  bit sa [0:8191];
  bit sb [0:8191];
  bit     mm_have_min, mm_have_max;
  longint mm_min, mm_max;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rising transitions in the sampled tick stream between two sample indices.
  function automatic longint raw_edges(input bit selb, input int lo_n, input int hi_n);
    longint k = 0;
    for (int n = (lo_n < 2 ? 2 : lo_n); n <= hi_n; n++) begin
      if (selb ? (sb[n] && !sb[n-1]) : (sa[n] && !sa[n-1])) k++;
    end
    return k;
  endfunction

  // Window w covers cycles [1,G] for the first window, else [(w-1)(G+1), w(G+1)-1];
  // an edge visible in cycle c came from tick sample c-1 with two sync stages.
  task automatic on_valid_a();
    int lo, hi;
    longint raw, mx, ec;
    bit eo;
    wa++;
    lo  = (wa == 1) ? 1 : (wa - 1) * (GA + 1);
    hi  = wa * (GA + 1) - 1;
    raw = raw_edges(1'b0, lo - 1, hi - 1);
    mx  = 64'hFFFF_FFFF;
    ec  = (raw > mx) ? mx : raw;
    eo  = (raw > mx);
    chk("cnt_a", cnt_a, ec);
    chk("ovf_a", ovf_a, eo);
    chk("led_a", led_a, (ec >> 2) & 255);
`ifdef RING_FREQ_MINMAX_EN
    if (eo) mm_max = mx;
    else if (!mm_have_max || ec > mm_max) mm_max = ec;
    mm_have_max = 1'b1;
    if (!eo && (!mm_have_min || ec < mm_min)) begin
      mm_min = ec;
      mm_have_min = 1'b1;
    end
    chk("min_a", min_a, mm_min);
    chk("max_a", max_a, mm_max);
`endif
  endtask

  task automatic on_valid_b();
    int lo, hi;
    longint raw, mx, ec;
    bit eo;
    wb++;
    lo  = (wb == 1) ? 1 : (wb - 1) * (GB + 1);
    hi  = wb * (GB + 1) - 1;
    raw = raw_edges(1'b1, lo - 1, hi - 1);
    mx  = (64'd1 << WB) - 1;
    ec  = (raw > mx) ? mx : raw;
    eo  = (raw > mx);
    chk("cnt_b", cnt_b, ec);
    chk("ovf_b", ovf_b, eo);
    chk("led_b", led_b, ec & 255);
    if (wb == 1) begin
      chk("sat_cnt_b", cnt_b, 255);
      chk("sat_ovf_b", ovf_b, 1);
    end
    if (wb == 4) begin
      chk("quiet_cnt_b", cnt_b, 0);
      chk("quiet_ovf_b", ovf_b, 0);
    end
  endtask

  task automatic drive_ticks();
    int m;
    m = cyc + 1;
    if (m < 303)       tick_a = 1'b1;
    else if (m < 606)  tick_a = ((m % 4) < 2);
    else if (m < 1616) tick_a = ((m % 3) == 0);
    else begin
      if (a_run == 0) begin
        a_lvl = !a_lvl;
        a_run = a_lvl ? $urandom_range(1, 4) : $urandom_range(2, 5);
      end
      tick_a = a_lvl;
      a_run--;
    end
    tick_b = (m < 1700) ? ((m % 3) == 0) : 1'b1;
  endtask

  task automatic step();
    bit exp_va, exp_vb;
    @(posedge clk_25mhz);
    cyc++;
    sa[cyc] = tick_a;
    sb[cyc] = tick_b;
    #1;
    exp_va = (cyc >= GA + 2) && (((cyc - 1) % (GA + 1)) == 0);
    exp_vb = (cyc >= GB + 2) && (((cyc - 1) % (GB + 1)) == 0);
    if (vld_a !== 1'b0 || exp_va) begin
      chk("vld_a", vld_a, exp_va);
      if (vld_a === 1'b1 && exp_va) on_valid_a();
    end
    if (vld_b !== 1'b0 || exp_vb) begin
      chk("vld_b", vld_b, exp_vb);
      if (vld_b === 1'b1 && exp_vb) on_valid_b();
    end
    @(negedge clk_25mhz);
    drive_ticks();
  endtask

  task automatic model_reset();
    cyc = 0; wa = 0; wb = 0;
    a_run = 0; a_lvl = 1'b0;
    mm_have_min = 1'b0; mm_have_max = 1'b0;
    mm_min = 0; mm_max = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cnt_a"}, cnt_a, 0);
    chk({tag, "_vld_a"}, vld_a, 0);
    chk({tag, "_ovf_a"}, ovf_a, 0);
    chk({tag, "_led_a"}, led_a, 0);
    chk({tag, "_cnt_b"}, cnt_b, 0);
    chk({tag, "_ovf_b"}, ovf_b, 0);
`ifdef RING_FREQ_MINMAX_EN
    chk({tag, "_min_a"}, min_a, 0);
    chk({tag, "_max_a"}, max_a, 0);
`endif
  endtask

  initial begin
    int first;
    rst_n  = 1'b0;
    tick_a = 1'b1;
    tick_b = 1'b1;
    model_reset();

    // Tick held high through reset, then constant, periodic, max-rate and random.
    repeat (3) @(negedge clk_25mhz);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3300) step();
    chk("windows_a", wa, 32);
    chk("windows_b", wb, 4);

    // Asynchronous reset pulse in the middle of a window.
    #5 rst_n = 1'b0;
    #1 chk_zero("midreset");
    #30;
    model_reset();
    tick_a = 1'b1;
    tick_b = 1'b1;
    rst_n  = 1'b1;
    first  = 0;
    for (int i = 0; i < 300 && first == 0; i++) begin
      step();
      if (vld_a === 1'b1) first = cyc;
    end
    chk("first_valid_a", first, GA + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
